// File: rtl/sd_read_scheduler.sv
// sd_read_scheduler: round-robin arbitrated SD single-block read sequencer over a byte-wide SPI engine
module sd_read_scheduler #(
  parameter int RESP_POLL   = 8,
  parameter int TOKEN_POLL  = 1024,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_done,
  output logic        sd_cs,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [7:0]  r1
);
  localparam int M0 = RESP_POLL > TOKEN_POLL ? RESP_POLL : TOKEN_POLL;
  localparam int M1 = M0 > BLOCK_BYTES ? M0 : BLOCK_BYTES;
  localparam int MAXC = M1 > 6 ? M1 : 6;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [3:0] {IDLE, PRE, CMD, R1, TOKEN, DATA, CRC, POST, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ptr_q, ptr_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0] grant_q, grant_d;
  logic busy_q, busy_d, spi_start_q, spi_start_d, sd_cs_q, sd_cs_d;
  logic [7:0] spi_tx_q, spi_tx_d, data_out_q, data_out_d, r1_q, r1_d;
  logic data_valid_q, data_valid_d, data_last_q, data_last_d, done_q, done_d, err_q, err_d;
  logic [2:0] err_code_q, err_code_d;
  logic byte_ev, win;
  logic [7:0] tx_byte;
  // command frame bytes come from the latched address; every other byte is a 0xFF clock-out
  always_comb begin
    tx_byte = state_q != CMD ? 8'hFF :
              cnt_q == CW'(0) ? 8'h51 :
              cnt_q == CW'(1) ? addr_q[31:24] :
              cnt_q == CW'(2) ? addr_q[23:16] :
              cnt_q == CW'(3) ? addr_q[15:8] :
              cnt_q == CW'(4) ? addr_q[7:0] : 8'hFF;
  end
  // next-state logic: one byte in flight at a time, state advances on its completion
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    grant_d      = grant_q;
    spi_start_d  = 1'b0;
    spi_tx_d     = spi_tx_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;
    err_code_d   = err_code_q;
    r1_d         = r1_q;
    byte_ev      = pend_q && spi_done;
    win          = (&req) ? ptr_q : req[1];
    if (state_q != IDLE && state_q != DONE && !pend_q) begin
      spi_start_d = 1'b1;
      spi_tx_d    = tx_byte;
      pend_d      = 1'b1;
    end
    if (byte_ev) pend_d = 1'b0;
    unique case (state_q)
      IDLE: if (|req) begin
        grant_d    = win ? 2'b10 : 2'b01;
        ptr_d      = ~win;
        addr_d     = win ? addr1 : addr0;
        err_code_d = 3'd0;
        state_d    = PRE;
      end
      PRE: if (byte_ev) state_d = CMD;
      CMD: if (byte_ev) begin
        state_d = cnt_q == CW'(5) ? R1 : CMD;
        cnt_d   = cnt_q + 1'b1;
      end
      R1: if (byte_ev) begin
        if (!spi_rx[7]) begin
          r1_d       = spi_rx;
          err_code_d = spi_rx == 8'h00 ? 3'd0 : 3'd1;
          state_d    = spi_rx == 8'h00 ? TOKEN : POST;
        end else if (cnt_q == CW'(RESP_POLL - 1)) begin
          err_code_d = 3'd2;
          state_d    = POST;
        end else cnt_d = cnt_q + 1'b1;
      end
      TOKEN: if (byte_ev) begin
        if (spi_rx == 8'hFE) state_d = DATA;
        else if (spi_rx[7:5] == 3'b000 && spi_rx != 8'h00) begin
          err_code_d = 3'd3;
          state_d    = POST;
        end else if (cnt_q == CW'(TOKEN_POLL - 1)) begin
          err_code_d = 3'd4;
          state_d    = POST;
        end else cnt_d = cnt_q + 1'b1;
      end
      DATA: if (byte_ev) begin
        data_valid_d = 1'b1;
        data_out_d   = spi_rx;
        data_last_d  = cnt_q == CW'(BLOCK_BYTES - 1);
        state_d      = data_last_d ? CRC : DATA;
        cnt_d        = cnt_q + 1'b1;
      end
      CRC: if (byte_ev) begin
        state_d = cnt_q == CW'(1) ? POST : CRC;
        cnt_d   = cnt_q + 1'b1;
      end
      POST: if (byte_ev) state_d = DONE;
      default: state_d = IDLE;
    endcase
    cnt_d      = state_d != state_q ? '0 : cnt_d;
    grant_d    = state_d == IDLE ? 2'b00 : grant_d;
    busy_d     = state_d != IDLE;
    sd_cs_d    = !(state_d inside {PRE, CMD, R1, TOKEN, DATA, CRC});
    done_d     = state_d == DONE;
    err_d      = done_d && err_code_d != 3'd0;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      ptr_q        <= 1'b0;
      addr_q       <= '0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      spi_start_q  <= 1'b0;
      spi_tx_q     <= 8'hFF;
      sd_cs_q      <= 1'b1;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 3'd0;
      r1_q         <= 8'hFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      spi_start_q  <= spi_start_d;
      spi_tx_q     <= spi_tx_d;
      sd_cs_q      <= sd_cs_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      r1_q         <= r1_d;
    end
  end
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign spi_start  = spi_start_q;
  assign spi_tx     = spi_tx_q;
  assign sd_cs      = sd_cs_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign data_last  = data_last_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign r1         = r1_q;
endmodule

// File: tb/tb_sd_read_scheduler.sv
// tb_sd_read_scheduler: randomized SD card responder with a transaction-level reference model
module tb_sd_read_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req;
  logic [31:0] addr0, addr1;
  logic [1:0] grant;
  logic busy, spi_start, spi_done, sd_cs, data_valid, data_last, done, err;
  logic [7:0] spi_tx, spi_rx, data_out, r1;
  logic [2:0] err_code;
  localparam int LIM = 20000;

  sd_read_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .grant(grant), .busy(busy), .spi_start(spi_start), .spi_tx(spi_tx),
    .spi_rx(spi_rx), .spi_done(spi_done), .sd_cs(sd_cs), .data_out(data_out),
    .data_valid(data_valid), .data_last(data_last), .done(done), .err(err),
    .err_code(err_code), .r1(r1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // card side: bytes returned per transfer of the current transaction, 0xFF once exhausted
  logic [7:0] resp [0:2047];
  int resp_len = 0;
  int gen = 0;
  int stray_want = 0;
  int stray_got = 0;
  int pviol = 0;
  initial begin
    int idx, lg, d;
    logic [7:0] tx;
    spi_done = 1'b0;
    spi_rx = 8'h00;
    idx = 0;
    lg = 0;
    forever begin
      @(negedge clk);
      if (stray_got < stray_want && !spi_start) begin
        spi_rx = 8'hFE;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        stray_got++;
      end else if (spi_start) begin
        if (gen != lg) begin
          idx = 0;
          lg = gen;
        end
        tx = spi_tx;
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          if (spi_start || spi_tx !== tx) pviol++;
        end
        spi_rx = idx < resp_len ? resp[idx] : 8'hFF;
        idx++;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        if (spi_start) pviol++;
      end
    end
  end

  // passive observation of everything the DUT emits
  logic [7:0] got_tx[$];
  bit got_cs[$];
  logic [7:0] got_data[$];
  int last_idx[$];
  int gviol = 0;
  int dviol = 0;
  logic [1:0] gseen = 2'b00;
  bit pdone = 1'b0;
  always @(negedge clk) begin
    if (spi_start) begin
      got_tx.push_back(spi_tx);
      got_cs.push_back(sd_cs);
    end
    if (data_valid) begin
      if (data_last) last_idx.push_back(got_data.size());
      got_data.push_back(data_out);
    end
    if (data_last && !data_valid) dviol++;
    if (done && pdone) dviol++;
    if (err && !done) dviol++;
    pdone = done;
    if (busy && gseen != 2'b00 && grant !== gseen) gviol++;
    gseen = busy ? grant : 2'b00;
  end

  int tie = 0;
  logic [7:0] r1m = 8'hFF;

  task automatic run_txn(input logic [1:0] rq, input int p, input logic [7:0] r1v,
                         input int tp, input logic [7:0] tok, input bit seq, input bit abort);
    int win, n, k, tb0, db0, lb0, mism, csm, n_r1, n_tok, s;
    bit r1_ok, dat_ok;
    logic [31:0] a;
    logic [2:0] ec;
    logic [7:0] etx[$];
    logic [7:0] edat[$];
    win = rq == 2'b11 ? tie : (rq[1] ? 1 : 0);
    addr0 = seq ? 32'h0000_0010 : $urandom;
    addr1 = $urandom;
    a = win == 1 ? addr1 : addr0;
    n = 0;
    repeat (7) resp[n++] = 8'hFF;
    repeat (p) resp[n++] = 8'hFF;
    r1_ok = p < 8 && r1v == 8'h00;
    dat_ok = r1_ok && tp < 1024 && tok == 8'hFE;
    if (p < 8) resp[n++] = r1v;
    if (r1_ok) begin
      repeat (tp) resp[n++] = 8'hFF;
      if (tp < 1024) resp[n++] = tok;
    end
    if (dat_ok)
      for (int i = 0; i < 512; i++) begin
        resp[n] = seq ? 8'(i % 256) : 8'($urandom);
        edat.push_back(resp[n]);
        n++;
      end
    resp_len = n;
    ec = p >= 8 ? 3'd2 : r1v != 8'h00 ? 3'd1 : tp >= 1024 ? 3'd4 : tok == 8'hFE ? 3'd0 : 3'd3;
    n_r1 = p < 8 ? p + 1 : 8;
    n_tok = tp < 1024 ? tp + 1 : 1024;
    etx = '{8'hFF, 8'h51, a[31:24], a[23:16], a[15:8], a[7:0], 8'hFF};
    repeat (n_r1 + (r1_ok ? n_tok : 0) + (dat_ok ? 514 : 0) + 1) etx.push_back(8'hFF);
    if (p < 8) r1m = r1v;
    gen++;
    tb0 = got_tx.size();
    db0 = got_data.size();
    lb0 = last_idx.size();
    @(negedge clk);
    req = rq;
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("busy_up", busy, 1);
    chk("grant", grant, win == 1 ? 2'b10 : 2'b01);
    tie = 1 - win;
    k = 0;
    while (!done && k < LIM && !(abort && got_data.size() - db0 >= 100)) begin
      @(negedge clk);
      req = 2'($urandom);
      k++;
    end
    req = 2'b00;
    if (abort) begin
      chk("abort_point", got_data.size() - db0 >= 100, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_cs", sd_cs, 1);
      chk("rst_grant", grant, 0);
      chk("rst_start", spi_start, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_ec", err_code, 0);
      chk("rst_r1", r1, 8'hFF);
      rst = 1'b0;
      tie = 0;
      r1m = 8'hFF;
      repeat (10) @(negedge clk);
      s = got_tx.size();
      stray_want++;
      k = 0;
      while (stray_got < stray_want && k < 20) begin
        @(negedge clk);
        k++;
      end
      repeat (6) @(negedge clk);
      chk("stray_sent", stray_got, stray_want);
      chk("stray_no_start", got_tx.size() - s, 0);
      chk("stray_idle", busy, 0);
      return;
    end
    chk("done_seen", done, 1);
    chk("err", err, ec != 3'd0);
    chk("err_code", err_code, ec);
    chk("r1", r1, r1m);
    chk("cs_at_done", sd_cs, 1);
    chk("tx_count", got_tx.size() - tb0, etx.size());
    mism = 0;
    csm = 0;
    for (int i = 0; i < etx.size() && tb0 + i < got_tx.size(); i++) begin
      if (got_tx[tb0 + i] !== etx[i]) mism++;
      if (got_cs[tb0 + i] != (i == etx.size() - 1)) csm++;
    end
    chk("tx_bytes", mism, 0);
    chk("cs_pattern", csm, 0);
    chk("data_count", got_data.size() - db0, edat.size());
    mism = 0;
    for (int i = 0; i < edat.size() && db0 + i < got_data.size(); i++)
      if (got_data[db0 + i] !== edat[i]) mism++;
    chk("data_bytes", mism, 0);
    chk("last_count", last_idx.size() - lb0, edat.size() != 0 ? 1 : 0);
    if (last_idx.size() > lb0) chk("last_pos", last_idx[lb0] - db0, 511);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("grant_after", grant, 0);
    chk("ec_hold", err_code, ec);
  endtask

  initial begin
    int p, tp;
    logic [7:0] r1v, tok;
    rst = 1'b1;
    req = 2'b00;
    addr0 = '0;
    addr1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_cs", sd_cs, 1);
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    chk("reset_start", spi_start, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_ec", err_code, 0);
    chk("reset_r1", r1, 8'hFF);
    chk("reset_valid", data_valid, 0);
    chk("reset_last", data_last, 0);
    chk("reset_dout", data_out, 0);
    rst = 1'b0;
    run_txn(2'b11, 1, 8'h00, 2, 8'hFE, 0, 0);
    run_txn(2'b11, 0, 8'h00, 0, 8'hFE, 0, 0);
    run_txn(2'b01, 2, 8'h00, 1, 8'hFE, 1, 0);
    run_txn(2'b10, 8, 8'h00, 0, 8'hFE, 0, 0);
    run_txn(2'b11, 12, 8'h00, 0, 8'hFE, 0, 0);
    run_txn(2'b01, 3, 8'h04, 0, 8'hFE, 0, 0);
    run_txn(2'b10, 0, 8'h00, 3, 8'h08, 0, 0);
    run_txn(2'b01, 1, 8'h00, 1024, 8'hFE, 0, 0);
    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 9);
      r1v = $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 127)) : 8'h00;
      tp = $urandom_range(0, 6);
      tok = $urandom_range(0, 2) != 0 ? 8'hFE : 8'($urandom_range(1, 31));
      run_txn(2'($urandom_range(1, 3)), p, r1v, tp, tok, 0, 0);
    end
    run_txn(2'b01, 1, 8'h00, 2, 8'hFE, 0, 1);
    run_txn(2'b10, 1, 8'h00, 1, 8'hFE, 0, 0);
    chk("spi_protocol", pviol, 0);
    chk("grant_stable", gviol, 0);
    chk("pulse_rules", dviol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
